// File: rtl/vga_pkg.sv
// Shared types and constants for the parametrised VGA output stage:
// timing descriptors, the overlay levels and the per-pixel control bundle
// carried alongside the frame-buffer read latency.
package vga_pkg;

    typedef struct packed {
        logic [15:0] active;
        logic [15:0] fp;
        logic [15:0] sync;
        logic [15:0] bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_H = '{active: 16'd640, fp: 16'd16, sync: 16'd96, bp: 16'd48};
    localparam vga_timing_t VGA_640X480_V = '{active: 16'd480, fp: 16'd10, sync: 16'd2,  bp: 16'd33};

    // Overlay levels; truncated to the channel width at the point of use.
    localparam logic [7:0] OVL_ON_LVL  = 8'hFF;
    localparam logic [7:0] OVL_OFF_LVL = 8'h02;

    localparam int NUM_CLASSES = 32'sd10;

    // Per-pixel control information that must stay aligned with read data.
    typedef struct packed {
        logic frame_start;
        logic ovl_sel;
        logic ovl_hit;
        logic vs;
        logic hs;
        logic active;
    } vga_ctl_t;

    // Total period of one axis in cycles (horizontal) or lines (vertical).
    function automatic int timing_total(input vga_timing_t t);
        return int'(t.active) + int'(t.fp) + int'(t.sync) + int'(t.bp);
    endfunction

    // Overlay colour level for a cell: the selected class cell is lit.
    function automatic logic [7:0] ovl_level(input logic sel);
        logic [7:0] lvl;
        if (sel) begin
            lvl = OVL_ON_LVL;
        end else begin
            lvl = OVL_OFF_LVL;
        end
        return lvl;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to keep raster control information in step
// with frame-buffer read data. Clears synchronously to RST_VAL.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // Shift the bundle one stage per clock; clear every stage on reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_out_gen2.sv
// Parametrised VGA output stage: raster counters, frame-buffer addressing with
// pixel replication, read-latency compensation, grey/RGB pixel drive and a
// ten-cell class-result overlay strip in the top-left corner.
module vga_out_gen2
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE     = int'(VGA_640X480_H.active),
    parameter int   H_FP         = int'(VGA_640X480_H.fp),
    parameter int   H_SYNC       = int'(VGA_640X480_H.sync),
    parameter int   H_BP         = int'(VGA_640X480_H.bp),
    parameter int   V_ACTIVE     = int'(VGA_640X480_V.active),
    parameter int   V_FP         = int'(VGA_640X480_V.fp),
    parameter int   V_SYNC       = int'(VGA_640X480_V.sync),
    parameter int   V_BP         = int'(VGA_640X480_V.bp),
    parameter logic HSYNC_ACTIVE = 1'b0,
    parameter logic VSYNC_ACTIVE = 1'b0,
    parameter int   PIX_W        = 32'sd4,
    parameter int   SCALE_LOG2   = 32'sd0,
    parameter int   RD_LAT       = 32'sd1,
    parameter int   CELL         = 32'sd8,
    localparam int  SRC_W        = H_ACTIVE >> SCALE_LOG2,
    localparam int  SRC_H        = V_ACTIVE >> SCALE_LOG2,
    localparam int  ADDR_W       = $clog2(SRC_W * SRC_H)
) (
    input  logic               clk24,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  frame_addr,
    input  logic [3*PIX_W-1:0] frame_pixel,
    input  logic               rgb_mode,
    input  logic               ovl_en,
    input  logic [3:0]         result,
    input  logic               result_valid,
    output logic [PIX_W-1:0]   vga_red,
    output logic [PIX_W-1:0]   vga_green,
    output logic [PIX_W-1:0]   vga_blue,
    output logic               vga_hsync,
    output logic               vga_vsync,
    output logic               frame_start
);

    localparam vga_timing_t H_T = '{active: 16'(H_ACTIVE), fp: 16'(H_FP), sync: 16'(H_SYNC), bp: 16'(H_BP)};
    localparam vga_timing_t V_T = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC), bp: 16'(V_BP)};
    localparam int H_TOTAL = timing_total(H_T);
    localparam int V_TOTAL = timing_total(V_T);
    localparam int HCW     = $clog2(H_TOTAL);
    localparam int VCW     = $clog2(V_TOTAL);

    localparam logic [HCW-1:0]    H_LAST_C   = HCW'(H_TOTAL - 1);
    localparam logic [VCW-1:0]    V_LAST_C   = VCW'(V_TOTAL - 1);
    localparam logic [HCW-1:0]    H_ACT_C    = HCW'(H_ACTIVE);
    localparam logic [VCW-1:0]    V_ACT_C    = VCW'(V_ACTIVE);
    localparam logic [HCW-1:0]    HS_START_C = HCW'(H_ACTIVE + H_FP);
    localparam logic [HCW-1:0]    HS_END_C   = HCW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCW-1:0]    VS_START_C = VCW'(V_ACTIVE + V_FP);
    localparam logic [VCW-1:0]    VS_END_C   = VCW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [HCW-1:0]    OVL_W_C    = HCW'(NUM_CLASSES * CELL);
    localparam logic [VCW-1:0]    OVL_H_C    = VCW'(CELL);
    localparam logic [HCW-1:0]    CELL_C     = HCW'(CELL);
    localparam logic [ADDR_W-1:0] SRC_W_C    = ADDR_W'(SRC_W);
    localparam logic [3:0]        NUM_CLS_C  = 4'(NUM_CLASSES);

    // Raster position and read address
    logic [HCW-1:0]    hcnt_q, hcnt_d;
    logic [VCW-1:0]    vcnt_q, vcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // Frame-level state: latched colour mode, pending and shown class
    logic       mode_q, mode_d;
    logic [3:0] pending_q, pending_d;
    logic [3:0] shown_q, shown_d;

    // Stage-0 decode and its delayed copy
    vga_ctl_t       ctl0_s;
    vga_ctl_t       ctl_dly_s;
    logic [HCW-1:0] cell_lo_s;
    logic [HCW-1:0] cell_hi_s;

    // Pin registers and their next values
    logic [PIX_W-1:0] red_q, green_q, blue_q;
    logic [PIX_W-1:0] red_d, green_d, blue_d;
    logic             hsync_q, vsync_q, fstart_q;

    // Next raster position, wrapping both counters at their totals.
    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST_C) begin
            hcnt_d = '0;
            if (vcnt_q == V_LAST_C) begin
                vcnt_d = '0;
            end else begin
                vcnt_d = vcnt_q + VCW'(1);
            end
        end else begin
            hcnt_d = hcnt_q + HCW'(1);
        end
    end

    // Read address for the next position; replicated source pixels come from
    // dropping the low coordinate bits. Blanking reads address zero.
    always_comb begin
        if ((hcnt_d < H_ACT_C) && (vcnt_d < V_ACT_C)) begin
            addr_d = ADDR_W'(vcnt_d >> SCALE_LOG2) * SRC_W_C + ADDR_W'(hcnt_d >> SCALE_LOG2);
        end else begin
            addr_d = '0;
        end
    end

    // Advance the raster and register the address that matches it.
    always_ff @(posedge clk24) begin
        if (!rst_n) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            addr_q <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            addr_q <= addr_d;
        end
    end

    assign frame_addr = addr_q;

    // Horizontal bounds of the overlay cell for the currently shown class.
    assign cell_lo_s = HCW'(shown_q) * CELL_C;
    assign cell_hi_s = cell_lo_s + CELL_C;

    // Stage-0 decode of the current raster position.
    always_comb begin
        ctl0_s             = '0;
        ctl0_s.active      = (hcnt_q < H_ACT_C) && (vcnt_q < V_ACT_C);
        ctl0_s.hs          = (hcnt_q >= HS_START_C) && (hcnt_q < HS_END_C);
        ctl0_s.vs          = (vcnt_q >= VS_START_C) && (vcnt_q < VS_END_C);
        ctl0_s.ovl_hit     = ovl_en && (hcnt_q < OVL_W_C) && (vcnt_q < OVL_H_C);
        ctl0_s.ovl_sel     = (hcnt_q >= cell_lo_s) && (hcnt_q < cell_hi_s);
        ctl0_s.frame_start = (hcnt_q == '0) && (vcnt_q == '0);
    end

    // Mode is captured once per frame; a new class is promoted to the display
    // only at the start of vertical blank, so a frame is never torn. A result
    // arriving on the promotion cycle stays pending for the next blank.
    always_comb begin
        mode_d    = mode_q;
        shown_d   = shown_q;
        pending_d = pending_q;
        if (ctl0_s.frame_start) begin
            mode_d = rgb_mode;
        end else begin
            mode_d = mode_q;
        end
        if ((hcnt_q == '0) && (vcnt_q == V_ACT_C)) begin
            shown_d = pending_q;
        end else begin
            shown_d = shown_q;
        end
        if (result_valid && (result < NUM_CLS_C)) begin
            pending_d = result;
        end else begin
            pending_d = pending_q;
        end
    end

    // Hold the frame-level mode and overlay class state.
    always_ff @(posedge clk24) begin
        if (!rst_n) begin
            mode_q    <= 1'b0;
            pending_q <= 4'd0;
            shown_q   <= 4'd0;
        end else begin
            mode_q    <= mode_d;
            pending_q <= pending_d;
            shown_q   <= shown_d;
        end
    end

    vga_delay_line #(
        .WIDTH   ($bits(vga_ctl_t)),
        .DEPTH   (RD_LAT),
        .RST_VAL ('0)
    ) u_ctl_dly (
        .clk_i   (clk24),
        .rst_n_i (rst_n),
        .d_i     (ctl0_s),
        .q_o     (ctl_dly_s)
    );

    // Pixel selection for the pins: blank, overlay, or frame-buffer data.
    always_comb begin
        red_d   = '0;
        green_d = '0;
        blue_d  = '0;
        if (!ctl_dly_s.active) begin
            red_d   = '0;
            green_d = '0;
            blue_d  = '0;
        end else if (ctl_dly_s.ovl_hit) begin
            red_d   = PIX_W'(ovl_level(ctl_dly_s.ovl_sel));
            green_d = PIX_W'(ovl_level(ctl_dly_s.ovl_sel));
            blue_d  = PIX_W'(ovl_level(ctl_dly_s.ovl_sel));
        end else if (mode_q) begin
            red_d   = frame_pixel[3*PIX_W-1:2*PIX_W];
            green_d = frame_pixel[2*PIX_W-1:PIX_W];
            blue_d  = frame_pixel[PIX_W-1:0];
        end else begin
            red_d   = frame_pixel[PIX_W-1:0];
            green_d = frame_pixel[PIX_W-1:0];
            blue_d  = frame_pixel[PIX_W-1:0];
        end
    end

    // Output register driving the connector, aligned with returned read data.
    always_ff @(posedge clk24) begin
        if (!rst_n) begin
            red_q    <= '0;
            green_q  <= '0;
            blue_q   <= '0;
            hsync_q  <= ~HSYNC_ACTIVE;
            vsync_q  <= ~VSYNC_ACTIVE;
            fstart_q <= 1'b0;
        end else begin
            red_q    <= red_d;
            green_q  <= green_d;
            blue_q   <= blue_d;
            hsync_q  <= ctl_dly_s.hs ? HSYNC_ACTIVE : ~HSYNC_ACTIVE;
            vsync_q  <= ctl_dly_s.vs ? VSYNC_ACTIVE : ~VSYNC_ACTIVE;
            fstart_q <= ctl_dly_s.frame_start;
        end
    end

    assign vga_red     = red_q;
    assign vga_green   = green_q;
    assign vga_blue    = blue_q;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign frame_start = fstart_q;

endmodule

// File: tb/tb_vga_out_gen2.sv
// Scoreboard bench for vga_out_gen2 using a reduced raster so that many frames
// fit in a short run. A reference model computes each position's expected pin
// values from raster arithmetic; a monitor pops and compares them.
module tb_vga_out_gen2;

    localparam int HA = 96, HFP = 4, HSW = 8, HBP = 4;
    localparam int VA = 16, VFP = 2, VSW = 2, VBP = 2;
    localparam int PW = 4, SL = 1, RL = 2, CELL = 8;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;
    localparam int SW = HA >> SL;
    localparam int SH = VA >> SL;
    localparam int AW = $clog2(SW * SH);

    logic          clk24;
    logic          rst_n;
    logic [AW-1:0] frame_addr;
    logic [11:0]   frame_pixel;
    logic          rgb_mode;
    logic          ovl_en;
    logic [3:0]    result;
    logic          result_valid;
    logic [PW-1:0] vga_red, vga_green, vga_blue;
    logic          vga_hsync, vga_vsync, frame_start;

    vga_out_gen2 #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HSYNC_ACTIVE(1'b0), .VSYNC_ACTIVE(1'b0),
        .PIX_W(PW), .SCALE_LOG2(SL), .RD_LAT(RL), .CELL(CELL)
    ) dut (
        .clk24(clk24), .rst_n(rst_n), .frame_addr(frame_addr), .frame_pixel(frame_pixel),
        .rgb_mode(rgb_mode), .ovl_en(ovl_en), .result(result), .result_valid(result_valid),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .frame_start(frame_start)
    );

    initial begin
        clk24 = 1'b0;
        forever #5 clk24 = ~clk24;
    end

    // Frame-buffer model with RL cycles of read latency.
    logic [11:0] mem [SW*SH];
    logic [11:0] rd_pipe [RL];
    always @(posedge clk24) begin
        rd_pipe[0] <= mem[frame_addr];
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign frame_pixel = rd_pipe[RL-1];

    typedef struct packed {
        int         p;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hs;
        logic       vs;
        logic       fs;
    } pins_t;

    pins_t exp_q[$];
    int    pos;
    bit    live;
    bit    mode_m;
    int    pend_m, shown_m;
    int    checks, errors;
    int    max_addr;

    function automatic pins_t blank_pins();
        pins_t e;
        e = '{p: -1, r: 4'd0, g: 4'd0, b: 4'd0, hs: 1'b1, vs: 1'b1, fs: 1'b0};
        return e;
    endfunction

    function automatic int exp_addr(input int p);
        int x, y;
        x = p % HT;
        y = p / HT;
        if (x < HA && y < VA) return (y >> SL) * SW + (x >> SL);
        return 0;
    endfunction

    // Reference model: one expected pin record per raster position.
    task automatic model_step();
        pins_t       e;
        int          x, y, lvl;
        logic [11:0] px;
        if (!rst_n) begin
            exp_q.delete();
            for (int i = 0; i <= RL; i++) exp_q.push_back(blank_pins());
            pos = 0; mode_m = 1'b0; pend_m = 0; shown_m = 0; live = 1'b1;
        end else if (live) begin
            x = pos % HT;
            y = pos / HT;
            if (pos == 0) mode_m = rgb_mode;
            e    = blank_pins();
            e.p  = pos;
            e.hs = (x >= HA + HFP && x < HA + HFP + HSW) ? 1'b0 : 1'b1;
            e.vs = (y >= VA + VFP && y < VA + VFP + VSW) ? 1'b0 : 1'b1;
            e.fs = (pos == 0);
            if (x < HA && y < VA) begin
                if (ovl_en && x < 10 * CELL && y < CELL) begin
                    lvl = (x / CELL == shown_m) ? 15 : 2;
                    e.r = 4'(lvl); e.g = 4'(lvl); e.b = 4'(lvl);
                end else begin
                    px = mem[(y >> SL) * SW + (x >> SL)];
                    if (mode_m) begin
                        e.r = px[11:8]; e.g = px[7:4]; e.b = px[3:0];
                    end else begin
                        e.r = px[3:0]; e.g = px[3:0]; e.b = px[3:0];
                    end
                end
            end
            exp_q.push_back(e);
            if (x == 0 && y == VA) shown_m = pend_m;
            if (result_valid && result < 4'd10) pend_m = int'(result);
            pos = (pos + 1) % FRAME;
        end
    endtask

    // Monitor: compare pins against the oldest expectation, and the address.
    task automatic monitor_step();
        pins_t e;
        int    ea;
        if (live) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_empty at pos=%0d", pos);
            end else begin
                e = exp_q.pop_front();
                if ({vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_start} !==
                    {e.r, e.g, e.b, e.hs, e.vs, e.fs}) begin
                    errors++;
                    $display("FAIL pins pos=%0d got rgb=%h%h%h hs=%b vs=%b fs=%b expected rgb=%h%h%h hs=%b vs=%b fs=%b",
                             e.p, vga_red, vga_green, vga_blue, vga_hsync, vga_vsync, frame_start,
                             e.r, e.g, e.b, e.hs, e.vs, e.fs);
                end
            end
            ea = exp_addr(pos);
            checks++;
            if (int'(frame_addr) != ea) begin
                errors++;
                $display("FAIL frame_addr pos=%0d got %0d expected %0d", pos, frame_addr, ea);
            end
            if (int'(frame_addr) > max_addr) max_addr = int'(frame_addr);
        end
    endtask

    task automatic wait_pos(input int target);
        for (int i = 0; i < FRAME + 8; i++) begin
            @(negedge clk24);
            if (pos == target) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_pos timeout target=%0d got pos=%0d", target, pos);
    endtask

    task automatic pulse_result(input int at_pos, input logic [3:0] v);
        wait_pos(at_pos);
        result_valid = 1'b1;
        result       = v;
        @(negedge clk24);
        result_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rgb_mode = 1'b0; ovl_en = 1'b0; result = 4'd0; result_valid = 1'b0;
        pos = 0; live = 1'b0; mode_m = 1'b0; pend_m = 0; shown_m = 0;
        checks = 0; errors = 0; max_addr = 0;
        for (int i = 0; i < SW * SH; i++) mem[i] = 12'($urandom);
        mem[5] = 12'hABC;
        fork
            forever @(posedge clk24) model_step();
            forever @(negedge clk24) monitor_step();
        join_none

        repeat (4) @(negedge clk24);
        rst_n    = 1'b1;
        rgb_mode = 1'b1;
        ovl_en   = 1'b1;
        repeat (2 * FRAME) @(negedge clk24);

        // Mode change mid-frame only applies from the next frame.
        wait_pos(5 * HT + 3);
        rgb_mode = 1'b0;
        repeat (FRAME) @(negedge clk24);

        // Out-of-range class ignored; in-range class shown after blank.
        pulse_result(3 * HT, 4'd12);
        pulse_result(4 * HT, 4'd3);
        repeat (2 * FRAME) @(negedge clk24);

        // New result on the promotion cycle stays pending one more frame.
        rgb_mode = 1'b1;
        pulse_result(100, 4'd4);
        pulse_result(VA * HT, 4'd7);
        repeat (2 * FRAME) @(negedge clk24);

        // Randomised traffic on all control inputs.
        for (int i = 0; i < 8 * FRAME; i++) begin
            @(negedge clk24);
            result_valid = ($urandom_range(0, 99) == 0);
            result       = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1999) == 0) rgb_mode = ~rgb_mode;
            if ($urandom_range(0, 2999) == 0) ovl_en = ~ovl_en;
        end
        result_valid = 1'b0;
        ovl_en       = 1'b1;

        // One-cycle reset mid-frame restarts the raster.
        wait_pos(10 * HT + 5);
        rst_n = 1'b0;
        @(negedge clk24);
        rst_n = 1'b1;
        repeat (2 * FRAME) @(negedge clk24);

        checks++;
        if (max_addr != SW * SH - 1) begin
            errors++;
            $display("FAIL max_addr got %0d expected %0d", max_addr, SW * SH - 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
